// File: rtl/mem_access_master.sv
// Initiator for the parity-protected byte memory: one request at a time, single-cycle
// read/write strobes, parity-checked read responses on a valid/ready channel.
module mem_access_master #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_perr,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W:0]   data_out,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  perr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        lat_q, lat_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_perr_q, rsp_perr_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  perr_cnt_q, perr_cnt_d;
    logic              perr_w;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Even parity: stored MSB must equal the XOR of the data bits.
    assign perr_w = data_out[DATA_W] ^ (^data_out[DATA_W-1:0]);

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_perr_d  = rsp_perr_q;
        read_d      = 1'b0;
        write_d     = 1'b0;
        address_d   = address_q;
        data_in_d   = data_in_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        perr_cnt_d  = perr_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    address_d = req_addr;
                    data_in_d = req_wdata;
                    write_d   = req_write;
                    read_d    = ~req_write;
                    state_d   = req_write ? S_WR : S_RD;
                end
            end
            S_WR: begin
                wr_cnt_d = sat_inc(wr_cnt_q);
                state_d  = S_IDLE;
            end
            S_RD: begin
                lat_d   = 4'(READ_LAT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == 4'd1) begin
                    rsp_data_d  = data_out[DATA_W-1:0];
                    rsp_perr_d  = perr_w;
                    rsp_valid_d = 1'b1;
                    rd_cnt_d    = sat_inc(rd_cnt_q);
                    if (perr_w) perr_cnt_d = sat_inc(perr_cnt_q);
                    state_d = S_RESP;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lat_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_perr_q  <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= '0;
            data_in_q   <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            perr_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_perr_q  <= rsp_perr_d;
            read_q      <= read_d;
            write_q     <= write_d;
            address_q   <= address_d;
            data_in_q   <= data_in_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            perr_cnt_q  <= perr_cnt_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_perr  = rsp_perr_q;
    assign read      = read_q;
    assign write     = write_q;
    assign address   = address_q;
    assign data_in   = data_in_q;
    assign wr_cnt    = wr_cnt_q;
    assign rd_cnt    = rd_cnt_q;
    assign perr_cnt  = perr_cnt_q;

endmodule
